// File: rtl/lib_io.sv
// Shared constants for the IO responder: byte width, output-register states
// and the r_data field layout.
package lib_io;
  localparam int BYTE_W      = 8;
  localparam int RD_BYTE_LSB = 0;
  localparam int RD_OCC_LSB  = 8;
  localparam int RD_RSV_LSB  = 16;
  localparam int RD_DROP_LSB = 24;

  typedef enum logic {
    OR_EMPTY = 1'b0,
    OR_HOLD  = 1'b1
  } oreg_state_t;
endpackage

// File: rtl/io_fifo.sv
// Byte FIFO with wrap-around pointers; the extra pointer MSB separates full
// from empty. Callers guarantee push only when not full (or popping) and pop only when not empty.
module io_fifo
  import lib_io::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [BYTE_W-1:0]        din,
  output logic [BYTE_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the head is only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/io_responder.sv
// CPU-facing IO responder: RX FIFO read via irr/ack, TX FIFO drained through a
// registered valid/ready output. Define IO_DROP_CNT_EN for the RX drop counter.
module io_responder
  import lib_io::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              irr,
  input  logic              ack,
  output logic [31:0]       r_data,
  input  logic              w_req,
  input  logic [31:0]       w_data,
  output logic              w_busy,
  input  logic              in_stb,
  input  logic [BYTE_W-1:0] in_data,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data,
  input  logic              out_ready
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic [BYTE_W-1:0] rx_dout;
  logic [CW-1:0]     rx_count;
  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic [BYTE_W-1:0] tx_dout;
  logic [CW-1:0]     tx_count;
  logic [7:0]        drop_cnt;
  logic              unused_tx;

  // A full RX still accepts a byte when the CPU frees a slot on the same edge.
  assign rx_pop  = ack && !rx_empty;
  assign rx_push = in_stb && (!rx_full || rx_pop);
  assign tx_push = w_req && !tx_full;

  io_fifo #(.DEPTH(DEPTH)) u_rx (
    .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .din(in_data),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  io_fifo #(.DEPTH(DEPTH)) u_tx (
    .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .din(w_data[BYTE_W-1:0]),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  assign unused_tx = ^{w_data[31:BYTE_W], tx_count};

  oreg_state_t state, state_nxt;
  logic        load;

  always_ff @(posedge clk) begin
    if (reset) state <= OR_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      OR_EMPTY: if (!tx_empty) begin
        load      = 1'b1;
        state_nxt = OR_HOLD;
      end
      OR_HOLD: if (out_ready) begin
        if (!tx_empty) load = 1'b1;
        else           state_nxt = OR_EMPTY;
      end
      default: state_nxt = OR_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)     out_data <= '0;
    else if (load) out_data <= tx_dout;
  end

  assign tx_pop    = load;
  assign out_valid = (state == OR_HOLD);

`ifdef IO_DROP_CNT_EN
  logic drop;
  assign drop = in_stb && rx_full && !rx_pop;

  always_ff @(posedge clk) begin
    if (reset)                        drop_cnt <= '0;
    else if (drop && drop_cnt != '1)  drop_cnt <= drop_cnt + 8'd1;
  end
`else
  assign drop_cnt = '0;
`endif

  assign irr    = !rx_empty;
  assign w_busy = tx_full;

  always_comb begin
    r_data = '0;
    r_data[RD_BYTE_LSB +: BYTE_W] = rx_empty ? '0 : rx_dout;
    r_data[RD_OCC_LSB  +: 8]      = 8'(rx_count);
    r_data[RD_DROP_LSB +: 8]      = drop_cnt;
  end
endmodule
